// File: rtl/ecc_ks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_ks_pkg
// Description : Shared types and constants for the iterative 27-bit GF(2)
//               Karatsuba multiplier. Holds the controller state encoding,
//               the operand/product widths and the per-step table saying at
//               which 9-bit offsets each 17-bit partial product is folded
//               into the 53-bit result.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_ks_pkg;

  localparam int KS_W      = 27;  // operand width
  localparam int KS_SEG    = 9;   // Karatsuba segment width
  localparam int KS_PW     = 17;  // ks9 product width
  localparam int KS_YW     = 53;  // full product width
  localparam int KS_STEPS  = 6;   // ks9 products per multiplication
  localparam int KS_STEP_W = 3;   // step counter width
  localparam int KS_OFFS   = 5;   // candidate offsets 0/9/18/27/36

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ks_state_e;

  // Bit k set => the step's product is XORed in at offset k*KS_SEG.
  // The three diagonal products (steps 0, 1, 3) land at three offsets each;
  // this is how the "minus p_i" Karatsuba correction terms collapse in GF(2).
  function automatic logic [KS_OFFS-1:0] ks_shift_mask(input logic [KS_STEP_W-1:0] step);
    logic [KS_OFFS-1:0] m;
    case (step)
      3'd0:    m = 5'b00111;
      3'd1:    m = 5'b01110;
      3'd2:    m = 5'b00010;
      3'd3:    m = 5'b11100;
      3'd4:    m = 5'b00100;
      3'd5:    m = 5'b01000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // Zero-extend p and XOR together its copies at every offset in mask.
  function automatic logic [KS_YW-1:0] ks_place(input logic [KS_PW-1:0] p,
                                                 input logic [KS_OFFS-1:0] mask);
    logic [KS_YW-1:0] ext;
    logic [KS_YW-1:0] r;
    ext = {{(KS_YW-KS_PW){1'b0}}, p};
    r   = '0;
    for (int k = 0; k < KS_OFFS; k++) begin
      if (mask[k]) r = r ^ (ext << (k*KS_SEG));
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ks27_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ks27_iter_ctrl_if
// Description : Operand/result handshake bundle of the iterative 27-bit
//               carry-less multiplier.
// Signals     : in_valid/in_ready/a/b  operand channel (master -> block)
//               out_valid/out_ready/y  result channel  (block -> master)
//               busy                   block status
// Modports    : master (producer/consumer side), slave (multiplier side)
// Revision    : 1.0 - initial release
// ============================================================================
interface ks27_iter_ctrl_if;
  import ecc_ks_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [KS_W-1:0]  a;
  logic [KS_W-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic [KS_YW-1:0] y;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );

endinterface
`default_nettype wire

// File: rtl/ks9.sv
`default_nettype none
// ============================================================================
// Module      : ks9
// Description : Combinational 9x9 carry-less (GF(2)[x]) multiplier.
// Ports       : i_a [8:0]   multiplicand polynomial
//               i_b [8:0]   multiplier polynomial
//               o_p [16:0]  product polynomial
// Revision    : 1.0 - initial release
// ============================================================================
module ks9
  import ecc_ks_pkg::*;
(
  input  logic [KS_SEG-1:0] i_a,
  input  logic [KS_SEG-1:0] i_b,
  output logic [KS_PW-1:0]  o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < KS_SEG; i++) begin
      if (i_b[i]) o_p = o_p ^ ({{(KS_PW-KS_SEG){1'b0}}, i_a} << i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ks27_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ks27_iter_ctrl
// Description : Iterative 27-bit carry-less Karatsuba multiplier. The six
//               ks9 products of the 3-way split are computed one after the
//               other on a single ks9 and XOR-accumulated into the 53-bit
//               result register, which drives y directly.
// Parameters  : KS_REG  1 = register the ks9 output, two cycles per step
//                       0 = accumulate the ks9 output in the same cycle
// Ports       : clk   clock, rising edge
//               rst   asynchronous active-high reset
//               bus   ks27_iter_ctrl_if.slave (in_valid/in_ready/a/b,
//                     out_valid/out_ready/y, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module ks27_iter_ctrl
  import ecc_ks_pkg::*;
#(
  parameter bit KS_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  ks27_iter_ctrl_if.slave  bus
);

  ks_state_e              r_state;
  ks_state_e              w_state_nxt;
  logic [KS_W-1:0]        r_a;
  logic [KS_W-1:0]        r_b;
  logic [KS_STEP_W-1:0]   r_step;
  logic                   r_phase;   // KS_REG=1: 0 = drive ks9, 1 = accumulate
  logic [KS_YW-1:0]       r_acc;

  logic [KS_SEG-1:0]      w_opa;
  logic [KS_SEG-1:0]      w_opb;
  logic [KS_PW-1:0]       w_p;
  logic [KS_PW-1:0]       w_p_acc;

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_step_fire;
  logic                   w_last_step;

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_step_fire = (r_state == MUL) & (KS_REG ? r_phase : 1'b1);
  assign w_last_step = w_step_fire & (r_step == KS_STEP_W'(KS_STEPS-1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_state_nxt = MUL;
      MUL:  if (w_last_step)  w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = bus.in_valid ? MUL : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // In DONE the result slot frees up in the same cycle it is consumed, so a
  // new operand pair can be taken without passing through IDLE.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: w_in_ready = 1'b1;
      MUL:  w_busy     = 1'b1;
      DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.y         = r_acc;

  // ------------------------------------------------------------- operand mux
  always_comb begin
    w_opa = r_a[KS_SEG-1:0];
    w_opb = r_b[KS_SEG-1:0];
    case (r_step)
      3'd0: begin w_opa = r_a[8:0];                w_opb = r_b[8:0];                end
      3'd1: begin w_opa = r_a[17:9];               w_opb = r_b[17:9];               end
      3'd2: begin w_opa = r_a[8:0]  ^ r_a[17:9];   w_opb = r_b[8:0]  ^ r_b[17:9];   end
      3'd3: begin w_opa = r_a[26:18];              w_opb = r_b[26:18];              end
      3'd4: begin w_opa = r_a[8:0]  ^ r_a[26:18];  w_opb = r_b[8:0]  ^ r_b[26:18];  end
      3'd5: begin w_opa = r_a[17:9] ^ r_a[26:18];  w_opb = r_b[17:9] ^ r_b[26:18];  end
      default: ;
    endcase
  end

  ks9 u_ks9 (
    .i_a (w_opa),
    .i_b (w_opb),
    .o_p (w_p)
  );

  generate
    if (KS_REG) begin : g_ks_reg
      logic [KS_PW-1:0] r_p;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_p <= '0;
        else     r_p <= w_p;
      end
      assign w_p_acc = r_p;
    end else begin : g_ks_comb
      assign w_p_acc = w_p;
    end
  endgenerate

  // ---------------------------------------------------------------- datapath
  // Step 0 overwrites instead of XORing, so y keeps the previous result
  // through the accept edge and only changes once MUL really starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_step  <= '0;
      r_phase <= 1'b0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_step  <= '0;
      r_phase <= 1'b0;
    end else if (r_state == MUL) begin
      if (KS_REG) r_phase <= ~r_phase;
      if (w_step_fire) begin
        r_acc <= ((r_step == '0) ? '0 : r_acc) ^ ks_place(w_p_acc, ks_shift_mask(r_step));
        if (!w_last_step) r_step <= r_step + KS_STEP_W'(1);
      end
    end
  end

  a_step_range : assert property (@(posedge clk) disable iff (rst) r_step < KS_STEP_W'(KS_STEPS));

endmodule
`default_nettype wire

// File: tb/tb_ks27_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ks27_iter_ctrl
// Description : Self-checking bench. Two instances (KS_REG=0 and KS_REG=1)
//               share one stimulus; each has a transaction-level model
//               (pending product, accept cycle, fixed latency) checked on
//               every negedge, plus directed literal checks on instance 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ks27_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [26:0] a_in;
  logic [26:0] b_in;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [52:0] clmul(input logic [26:0] x, input logic [26:0] y);
    logic [52:0] r;
    r = '0;
    for (int i = 0; i < 27; i++) if (y[i]) r = r ^ ({26'b0, x} << i);
    return r;
  endfunction

  task automatic check(input int inst, input string name,
                       input logic [52:0] act, input logic [52:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL k%0d %s: got %h want %h", inst, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 7 : 13;

    ks27_iter_ctrl_if bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a_in;
    assign bus.b         = b_in;
    assign bus.out_ready = out_ready;

    ks27_iter_ctrl #(.KS_REG(g == 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    bit          pend = 1'b0;
    logic [52:0] pend_y;
    logic [52:0] last_y;
    int          pend_cyc;

    always @(negedge clk) begin
      bit ev;
      bit rdy_exp;
      if (rst) begin
        pend   = 1'b0;
        last_y = '0;
        check(g, "rst out_valid", 53'(bus.out_valid), 53'd0);
        check(g, "rst in_ready",  53'(bus.in_ready),  53'd1);
        check(g, "rst busy",      53'(bus.busy),      53'd0);
        check(g, "rst y",         bus.y,              53'd0);
      end else begin
        ev      = pend && ((cyc - pend_cyc) >= LAT);
        rdy_exp = !pend || (ev && out_ready);
        check(g, "out_valid", 53'(bus.out_valid), 53'(ev));
        check(g, "busy",      53'(bus.busy),      53'(pend));
        check(g, "in_ready",  53'(bus.in_ready),  53'(rdy_exp));
        if (ev)         check(g, "y result", bus.y, pend_y);
        else if (!pend) check(g, "y idle",   bus.y, last_y);
        if (ev && out_ready) begin
          last_y = pend_y;
          pend   = 1'b0;
        end
        if (in_valid && rdy_exp) begin
          pend     = 1'b1;
          pend_y   = clmul(a_in, b_in);
          pend_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((g_dut[0].bus.busy || g_dut[1].bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(0, "idle timeout", 53'(n < 200), 53'd1);
  endtask

  // Present one operand pair (with out_ready=rdy) for exactly one cycle and
  // wait for instance 0's result.
  task automatic do_op(input logic [26:0] a, input logic [26:0] b,
                       input logic [52:0] exp, input logic rdy, output int busy_n);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = a; b_in = b; out_ready = rdy;
    @(negedge clk);
    check(0, "accept in_ready", 53'(g_dut[0].bus.in_ready), 53'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (g_dut[0].bus.busy) busy_n++;
    end while (!g_dut[0].bus.out_valid && n < 40);
    check(0, "latency", 53'(n), 53'd7);
    check(0, "y literal", g_dut[0].bus.y, exp);
  endtask

  initial begin
    int bn;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;

    check(-1, "model 1*1",     clmul(27'h1, 27'h1), 53'h1);
    check(-1, "model 3*3",     clmul(27'h3, 27'h3), 53'h5);
    check(-1, "model ones*1",  clmul(27'h7FFFFFF, 27'h1), 53'h7FFFFFF);
    check(-1, "model top*top", clmul(27'h4000000, 27'h4000000), 53'h10000000000000);
    check(-1, "model 5*3",     clmul(27'h5, 27'h3), 53'hF);
    check(-1, "model 1ff sq",  clmul(27'h1FF, 27'h1FF), 53'h15555);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic op: 7 busy cycles, consumed immediately.
    do_op(27'h1, 27'h1, 53'h1, 1'b1, bn);
    check(0, "busy cycles", 53'(bn), 53'd7);
    @(negedge clk);
    check(0, "busy after", 53'(g_dut[0].bus.busy), 53'd0);
    wait_idle();

    do_op(27'h7FFFFFF, 27'h1, 53'h7FFFFFF, 1'b1, bn);
    wait_idle();
    do_op(27'h4000000, 27'h4000000, 53'h10000000000000, 1'b1, bn);
    wait_idle();

    // Backpressure, then back-to-back accept from DONE.
    do_op(27'h3, 27'h3, 53'h5, 1'b0, bn);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check(0, "hold y",         g_dut[0].bus.y,                53'h5);
      check(0, "hold out_valid", 53'(g_dut[0].bus.out_valid),   53'd1);
      check(0, "hold in_ready",  53'(g_dut[0].bus.in_ready),    53'd0);
    end
    do_op(27'h5, 27'h3, 53'hF, 1'b1, bn);
    wait_idle();

    // Asynchronous reset in the middle of step 3.
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 27'h7FFFFFF; b_in = 27'h7FFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check(0, "async rst out_valid", 53'(g_dut[0].bus.out_valid), 53'd0);
    check(0, "async rst y",         g_dut[0].bus.y,              53'd0);
    check(0, "async rst in_ready",  53'(g_dut[0].bus.in_ready),  53'd1);
    check(0, "async rst busy",      53'(g_dut[0].bus.busy),      53'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_op(27'h1FF, 27'h1FF, 53'h15555, 1'b1, bn);
    wait_idle();

    // Random traffic with gaps and backpressure on both sides.
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a_in      = 27'($urandom);
      b_in      = 27'($urandom);
      if ($urandom_range(15) == 0) begin
        a_in = (i % 2 == 0) ? 27'h7FFFFFF : 27'h4000000;
        b_in = 27'($urandom_range(1)) << 26;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
